// File: rtl/dequantize_pkg.sv
// Shared accelerator constants and FSM encoding, common to the quantizer and dequantizer.
package dequantize_pkg;

    localparam int LANES = 16;  // lanes per row
    localparam int ROWS  = 64;  // rows per vector block
    localparam int SF_W  = 40;  // scale factor / output width, Q30.10
    localparam int Q_W   = 4;   // quantized element width, signed INT4

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

endpackage

// File: rtl/dequant_lane.sv
// One lane: signed INT4 element times unsigned Q30.10 scale, truncated to SF_W bits.
module dequant_lane #(
    parameter int SF_W = dequantize_pkg::SF_W,
    parameter int Q_W  = dequantize_pkg::Q_W
) (
    input  logic [Q_W-1:0]  q,
    input  logic [SF_W-1:0] sf,
    output logic [SF_W-1:0] y
);

    logic [SF_W-1:0] q_ext;

    assign q_ext = {{(SF_W-Q_W){q[Q_W-1]}}, q};

    // Low SF_W bits of sext(q)*sf equal the truncated signed-by-unsigned product,
    // so a same-width unsigned multiply is exact here.
    assign y = q_ext * sf;

endmodule

// File: rtl/dequantize.sv
// Block dequantizer: streams ROWS INT4 rows from RAM and scales each lane by a banked Q30.10 factor.
module dequantize #(
    parameter int LANES = dequantize_pkg::LANES,
    parameter int ROWS  = dequantize_pkg::ROWS,
    parameter int SF_W  = dequantize_pkg::SF_W,
    parameter int Q_W   = dequantize_pkg::Q_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_sf_valid,
    input  logic [SF_W*LANES-1:0]     i_sf_data,
    input  logic                      i_start,
    output logic                      o_ram_re,
    output logic [$clog2(ROWS)-1:0]   o_ram_addr,
    input  logic [Q_W*LANES-1:0]      i_ram_data,
    output logic [SF_W*LANES-1:0]     o_data,
    output logic                      o_valid,
    output logic [$clog2(ROWS)-1:0]   o_idx,
    output logic                      o_busy,
    output logic                      o_done
);

    import dequantize_pkg::*;

    localparam int ADDR_W = $clog2(ROWS);

    state_t                  state;
    logic [SF_W*LANES-1:0]   sf_pending;
    logic [SF_W*LANES-1:0]   sf_active;
    logic                    sf_loaded;
    logic                    rd_valid;
    logic [ADDR_W-1:0]       rd_idx;
    logic [SF_W*LANES-1:0]   product;
    logic                    accept;

    assign accept = i_start && !o_busy && sf_loaded;

    // NOTE: the scale banks are plain registers, not a RAM, so they can and do take the async reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sf_pending <= '0;
            sf_active  <= '0;
            sf_loaded  <= 1'b0;
        end else begin
            if (i_sf_valid) begin
                sf_pending <= i_sf_data;
                sf_loaded  <= 1'b1;
            end
            // NOTE: non-blocking, so a coincident load still hands the old pending value to active.
            if (accept) begin
                sf_active <= sf_pending;
            end
        end
    end

    // Read sequencer; busy covers the read phase plus the two-cycle pipeline drain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            o_ram_re   <= 1'b0;
            o_ram_addr <= '0;
            o_busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_READ;
                        o_ram_re   <= 1'b1;
                        o_ram_addr <= '0;
                    end
                end
                ST_READ: begin
                    if (o_ram_addr == ADDR_W'(ROWS - 1)) begin
                        state      <= ST_IDLE;
                        o_ram_re   <= 1'b0;
                        o_ram_addr <= '0;
                    end else begin
                        o_ram_addr <= o_ram_addr + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    o_ram_re <= 1'b0;
                end
            endcase

            if (accept) begin
                o_busy <= 1'b1;
            end else if (o_done) begin
                o_busy <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dequant_lane #(
            .SF_W (SF_W),
            .Q_W  (Q_W)
        ) u_lane (
            .q  (i_ram_data[k*Q_W +: Q_W]),
            .sf (sf_active[k*SF_W +: SF_W]),
            .y  (product[k*SF_W +: SF_W])
        );
    end

    // Stage 1 tracks the cycle RAM data returns; stage 2 registers the scaled row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid <= 1'b0;
            rd_idx   <= '0;
            o_valid  <= 1'b0;
            o_done   <= 1'b0;
            o_idx    <= '0;
            o_data   <= '0;
        end else begin
            rd_valid <= o_ram_re;
            rd_idx   <= o_ram_addr;
            o_valid  <= rd_valid;
            o_done   <= rd_valid && (rd_idx == ADDR_W'(ROWS - 1));
            if (rd_valid) begin
                o_data <= product;
                o_idx  <= rd_idx;
            end
        end
    end

endmodule

// File: tb/tb_dequantize.sv
// Directed bench for dequantize: timing, arithmetic, scale banking, start filtering and reset abort.
module tb_dequantize;

    import dequantize_pkg::*;

    localparam int AW = $clog2(ROWS);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    sf_valid = 1'b0;
    logic [SF_W*LANES-1:0]   sf_data = '0;
    logic                    start = 1'b0;
    logic                    ram_re;
    logic [AW-1:0]           ram_addr;
    logic [Q_W*LANES-1:0]    ram_data = '0;
    logic [SF_W*LANES-1:0]   data;
    logic                    valid;
    logic [AW-1:0]           idx;
    logic                    busy;
    logic                    done;

    dequantize dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sf_valid (sf_valid),
        .i_sf_data  (sf_data),
        .i_start    (start),
        .o_ram_re   (ram_re),
        .o_ram_addr (ram_addr),
        .i_ram_data (ram_data),
        .o_data     (data),
        .o_valid    (valid),
        .o_idx      (idx),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM model: data appears the cycle after the read enable.
    logic [Q_W*LANES-1:0] mem [ROWS];
    always @(posedge clk) if (ram_re) ram_data <= mem[ram_addr];

    typedef struct {
        int                  idx;
        logic [SF_W*LANES-1:0] data;
        logic                done;
        int                  cyc;
    } beat_t;

    beat_t beats[$];
    int    re_addr[$];
    int    first_re_cyc = -1;
    int    busy_last = -1;
    beat_t mon_b;

    always @(negedge clk) begin
        if (valid) begin
            mon_b.idx  = int'(idx);
            mon_b.data = data;
            mon_b.done = done;
            mon_b.cyc  = cyc;
            beats.push_back(mon_b);
        end
        if (ram_re) begin
            if (re_addr.size() == 0) first_re_cyc = cyc;
            re_addr.push_back(int'(ram_addr));
        end
        if (busy) busy_last = cyc;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [SF_W-1:0] exp_tab [ROWS][LANES];

    function automatic logic [SF_W*LANES-1:0] sf_all(input logic [SF_W-1:0] v);
        logic [SF_W*LANES-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*SF_W +: SF_W] = v;
        return r;
    endfunction

    task automatic fill_uniform(input logic [3:0] nib, input logic [SF_W-1:0] e);
        for (int r = 0; r < ROWS; r++) begin
            mem[r] = {LANES{nib}};
            for (int k = 0; k < LANES; k++) exp_tab[r][k] = e;
        end
    endtask

    task automatic clear_mon();
        beats.delete();
        re_addr.delete();
        first_re_cyc = -1;
        busy_last = -1;
    endtask

    task automatic load_sf(input logic [SF_W*LANES-1:0] v);
        @(negedge clk);
        sf_valid = 1'b1;
        sf_data  = v;
        @(negedge clk);
        sf_valid = 1'b0;
    endtask

    task automatic start_run(output int t0);
        @(negedge clk);
        clear_mon();
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Full-run check against exp_tab: count, order, latency, done placement, read sequence, busy window.
    task automatic check_run(input string name, input int t0);
        int n;
        check({name, " beats"}, beats.size(), ROWS);
        n = (beats.size() < ROWS) ? beats.size() : ROWS;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s idx%0d", name, i), beats[i].idx, i);
            check($sformatf("%s lat%0d", name, i), beats[i].cyc - t0, 3 + i);
            check($sformatf("%s done%0d", name, i), beats[i].done, (i == ROWS - 1));
            for (int k = 0; k < LANES; k++)
                check($sformatf("%s r%0d l%0d", name, i, k),
                      beats[i].data[k*SF_W +: SF_W], exp_tab[i][k]);
        end
        check({name, " re_count"}, re_addr.size(), ROWS);
        check({name, " first_re"}, first_re_cyc - t0, 1);
        for (int i = 0; i < re_addr.size() && i < ROWS; i++)
            check($sformatf("%s addr%0d", name, i), re_addr[i], i);
        check({name, " busy_end"}, busy_last - t0, ROWS + 2);
    endtask

    initial begin
        int t0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst valid", valid, 0);
        check("rst done", done, 0);
        check("rst busy", busy, 0);
        check("rst ram_re", ram_re, 0);
        check("rst ram_addr", ram_addr, 0);
        check("rst idx", idx, 0);
        check("rst data", data[63:0], 0);
        rst_n = 1'b1;

        // Start with no scale loaded is ignored
        fill_uniform(4'h7, 40'hC400);
        start_run(t0);
        repeat (20) @(negedge clk);
        check("nosf re_count", re_addr.size(), 0);
        check("nosf busy", busy_last, -1);

        // 7.0 * 7 = 49.0 on every lane
        load_sf(sf_all(40'h1C00));
        start_run(t0);
        repeat (ROWS + 10) @(negedge clk);
        check_run("sf7", t0);

        // 1.0 with -8 / -1 alternating rows, plus an ignored mid-run start
        for (int r = 0; r < ROWS; r++) begin
            mem[r] = (r % 2 == 0) ? {LANES{4'h8}} : {LANES{4'hF}};
            for (int k = 0; k < LANES; k++)
                exp_tab[r][k] = (r % 2 == 0) ? 40'hFF_FFFF_E000 : 40'hFF_FFFF_FC00;
        end
        load_sf(sf_all(40'h400));
        start_run(t0);
        wait_cyc(t0 + 13);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (ROWS + 10) @(negedge clk);
        check_run("neg", t0);

        // Scale update during a run only takes effect on the next run
        fill_uniform(4'h3, 40'hC00);
        start_run(t0);
        wait_cyc(t0 + 33);
        sf_valid = 1'b1;
        sf_data  = sf_all(40'h800);
        @(negedge clk);
        sf_valid = 1'b0;
        repeat (ROWS + 10) @(negedge clk);
        check_run("sf1_hold", t0);
        fill_uniform(4'h3, 40'h1800);
        start_run(t0);
        repeat (ROWS + 10) @(negedge clk);
        check_run("sf2_next", t0);

        // Lane isolation: lane k scale (k+1), nibble k-8
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < LANES; k++) begin
                longint e;
                mem[r][k*Q_W +: Q_W] = 4'(k + 8);
                e = longint'(k - 8) * longint'(k + 1) * 1024;
                exp_tab[r][k] = e[SF_W-1:0];
            end
        for (int k = 0; k < LANES; k++) sf_data[k*SF_W +: SF_W] = SF_W'((k + 1) << 10);
        load_sf(sf_data);
        start_run(t0);
        repeat (ROWS + 10) @(negedge clk);
        check_run("lanes", t0);
        if (beats.size() > 0) begin
            check("lanes l0 lit", beats[0].data[0 +: SF_W], 40'hFF_FFFF_E000);
            check("lanes l8 lit", beats[0].data[8*SF_W +: SF_W], 40'h0);
            check("lanes l15 lit", beats[0].data[15*SF_W +: SF_W], 40'h1_C000);
        end

        // Reset at row 20 aborts at once
        fill_uniform(4'h1, 40'h400);
        load_sf(sf_all(40'h400));
        start_run(t0);
        wait_cyc(t0 + 23);
        #1;
        check("abort pre beats", beats.size(), 21);
        rst_n = 1'b0;
        #1;
        check("abort valid", valid, 0);
        check("abort done", done, 0);
        check("abort busy", busy, 0);
        check("abort ram_re", ram_re, 0);
        check("abort ram_addr", ram_addr, 0);
        check("abort idx", idx, 0);
        check("abort data", data[63:0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start_run(t0);
        repeat (ROWS + 10) @(negedge clk);
        check("post_rst beats", beats.size(), 0);
        check("post_rst re", re_addr.size(), 0);

        // Held start: second run accepted the cycle busy falls
        load_sf(sf_all(40'h400));
        @(negedge clk);
        clear_mon();
        start = 1'b1;
        t0 = cyc;
        wait_cyc(t0 + 68);
        start = 1'b0;
        repeat (ROWS + 10) @(negedge clk);
        check("b2b beats", beats.size(), 2 * ROWS);
        check("b2b re_count", re_addr.size(), 2 * ROWS);
        if (beats.size() >= ROWS + 1) begin
            check("b2b last1", beats[ROWS-1].cyc - t0, ROWS + 2);
            check("b2b done1", beats[ROWS-1].done, 1);
            check("b2b first2", beats[ROWS].cyc - t0, ROWS + 6);
            check("b2b idx2", beats[ROWS].idx, 0);
            check("b2b data2", beats[ROWS].data[0 +: SF_W], 40'h400);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
